// File: rtl/seq_lock_pkg.sv
// Shared types and helpers for the sequential code lock.
// State encoding and width helper used across the lock datapath.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ENTER   = 2'd0,
    ARMED   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // ceil(log2(v)), never below 1 so ports keep a usable width
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_code_lock_timer.sv
// Loadable down-counter with zero flag.
// Shared by the arm timeout and the lockout interval.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Parametrised sequential code lock with arm confirm,
// failed-attempt counting, timed lockout and arm timeout.
module seq_code_lock
  import seq_lock_pkg::*;
#(
  parameter int SYM_W       = 4,
  parameter int CODE_LEN    = 3,
  parameter     CODE        = 12'hF31,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYC    = 8,
  parameter int ARM_TIMEOUT = 16,
  localparam int PW = clog2(CODE_LEN + 1),
  localparam int FW = clog2(MAX_FAIL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_vld,
  input  logic [SYM_W-1:0] sym,
  input  logic             arm,
  input  logic             relock,
  output logic             unlocked,
  output logic             lockout,
  output logic [PW-1:0]    progress,
  output logic [FW-1:0]    fails
);

  localparam int TMAX = (LOCK_CYC > ARM_TIMEOUT) ? LOCK_CYC : ARM_TIMEOUT;
  localparam int TW   = clog2(TMAX);
  localparam int CW   = SYM_W * CODE_LEN;

  generate
    if (CODE_LEN < 1 || MAX_FAIL < 1 || LOCK_CYC < 1 ||
        ARM_TIMEOUT < 1 || $bits(CODE) != CW) begin : g_bad
      $error("seq_code_lock: illegal parameters");
    end
  endgenerate

  localparam logic [CW-1:0] CODE_V  = CODE;
  localparam logic [TW-1:0] ARM_LD  = TW'(ARM_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYC - 1);
  localparam logic [PW-1:0] LAST    = PW'(CODE_LEN - 1);
  localparam logic [PW-1:0] FULL    = PW'(CODE_LEN);
  localparam logic [FW-1:0] FMAX    = FW'(MAX_FAIL);

  state_t        state, state_n;
  logic [PW-1:0] idx, idx_n, prog_n;
  logic [FW-1:0] fails_n, fails_inc;
  logic [TW-1:0] t_val;
  logic          t_load, t_en, t_zero;
  logic          hit, first, fail_lock;

  assign hit       = (sym == CODE_V[int'(idx)*SYM_W +: SYM_W]);
  assign first     = (sym == CODE_V[0 +: SYM_W]);
  assign fails_inc = (fails == FMAX) ? fails : fails + 1'b1;
  assign fail_lock = (fails_inc == FMAX);
  assign t_en      = (state == ARMED) || (state == LOCKOUT);

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    fails_n = fails;
    t_load  = 1'b0;
    t_val   = ARM_LD;
    unique case (state)
      ENTER: begin
        if (sym_vld && hit) begin
          if (idx == LAST) begin
            state_n = ARMED;
            idx_n   = '0;
            t_load  = 1'b1;
            t_val   = ARM_LD;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else if (sym_vld && idx != '0) begin
          fails_n = fails_inc;
          if (fail_lock) begin
            state_n = LOCKOUT;
            idx_n   = '0;
            t_load  = 1'b1;
            t_val   = LOCK_LD;
          end else begin
            idx_n = first ? PW'(1) : '0;
          end
        end
      end
      ARMED: begin
        // arm wins over a timeout landing in the same cycle
        if (arm) begin
          state_n = OPEN;
          fails_n = '0;
        end else if (t_zero) begin
          state_n = ENTER;
          fails_n = fails_inc;
          if (fail_lock) begin
            state_n = LOCKOUT;
            t_load  = 1'b1;
            t_val   = LOCK_LD;
          end
        end
      end
      OPEN: begin
        if (relock) begin
          state_n = ENTER;
          idx_n   = '0;
        end
      end
      LOCKOUT: begin
        if (t_zero) begin
          state_n = ENTER;
          fails_n = '0;
        end
      end
      default: state_n = ENTER;
    endcase
  end

  always_comb begin
    prog_n = '0;
    unique case (state_n)
      ENTER:       prog_n = idx_n;
      ARMED, OPEN: prog_n = FULL;
      default:     prog_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENTER;
      idx      <= '0;
      fails    <= '0;
      unlocked <= 1'b0;
      lockout  <= 1'b0;
      progress <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      fails    <= fails_n;
      unlocked <= (state_n == OPEN);
      lockout  <= (state_n == LOCKOUT);
      progress <= prog_n;
    end
  end

endmodule

// File: tb/tb_seq_code_lock.sv
// Scoreboard bench for seq_code_lock: default 4-bit code
// instance plus a 1-bit serial-password instance.
module tb_seq_code_lock;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_vld, a_arm, a_rel;
  logic [3:0] a_sym;
  logic       a_unl, a_lck;
  logic [1:0] a_prog, a_fails;
  logic       b_vld, b_rel;
  logic [0:0] b_sym;
  logic       b_unl, b_lck;
  logic [2:0] b_prog;
  logic [1:0] b_fails;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit    sel;
    logic  u;
    logic  l;
    int    p;
    int    f;
    string nm;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  seq_code_lock u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_vld  (a_vld),
    .sym      (a_sym),
    .arm      (a_arm),
    .relock   (a_rel),
    .unlocked (a_unl),
    .lockout  (a_lck),
    .progress (a_prog),
    .fails    (a_fails)
  );

  seq_code_lock #(
    .SYM_W    (1),
    .CODE_LEN (4),
    .CODE     (4'b1011)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_vld  (b_vld),
    .sym      (b_sym),
    .arm      (1'b1),
    .relock   (b_rel),
    .unlocked (b_unl),
    .lockout  (b_lck),
    .progress (b_prog),
    .fails    (b_fails)
  );

  task automatic cmp(input string nm, input logic u, input logic l,
                     input int p, input int f, input exp_t x);
    n_tests++;
    if (u !== x.u || l !== x.l || p != x.p || f != x.f) begin
      n_fail++;
      $display("FAIL %s: got u=%0d l=%0d p=%0d f=%0d want u=%0d l=%0d p=%0d f=%0d",
               nm, u, l, p, f, x.u, x.l, x.p, x.f);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel)
        cmp(e.nm, b_unl, b_lck, int'(b_prog), int'(b_fails), e);
      else
        cmp(e.nm, a_unl, a_lck, int'(a_prog), int'(a_fails), e);
    end
  end

  task automatic step(input bit s, input logic v, input int sy,
                      input logic ar, input logic r,
                      input logic eu, input logic el,
                      input int ep, input int ef, input string nm);
    exp_t x;
    @(negedge clk);
    if (!s) begin
      a_vld = v; a_sym = sy[3:0]; a_arm = ar; a_rel = r;
    end else begin
      b_vld = v; b_sym = sy[0]; b_rel = r;
    end
    @(posedge clk);
    x.sel = s; x.u = eu; x.l = el; x.p = ep; x.f = ef; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic sa(input logic v, input int sy, input logic ar,
                    input logic r, input logic eu, input logic el,
                    input int ep, input int ef, input string nm);
    step(1'b0, v, sy, ar, r, eu, el, ep, ef, nm);
  endtask

  task automatic sb(input logic v, input int sy, input logic r,
                    input logic eu, input int ep, input int ef,
                    input string nm);
    step(1'b1, v, sy, 1'b1, r, eu, 1'b0, ep, ef, nm);
  endtask

  task automatic chk_now(input string nm);
    exp_t z;
    z.sel = 0; z.u = 0; z.l = 0; z.p = 0; z.f = 0; z.nm = nm;
    cmp(nm, a_unl, a_lck, int'(a_prog), int'(a_fails), z);
    cmp({nm, "_b"}, b_unl, b_lck, int'(b_prog), int'(b_fails), z);
  endtask

  task automatic rst_mid(input string nm);
    @(negedge clk);
    a_vld = 0; a_arm = 0; a_rel = 0;
    #2 rst_n = 1'b0;
    #1 chk_now(nm);
    #1 rst_n = 1'b1;
  endtask

  task automatic bad_tries();
    for (int i = 0; i < 3; i++) begin
      sa(1, 1, 0, 0, 0, 0, 1, i, "lk_s1");
      sa(1, 2, 0, 0, 0, (i == 2), 0, i + 1, "lk_s2");
    end
  endtask

  int hs[7] = '{1, 3, 15, 1, 3, 15, 1};

  initial begin
    rst_n = 1'b0;
    a_vld = 0; a_sym = '0; a_arm = 0; a_rel = 0;
    b_vld = 0; b_sym = '0; b_rel = 0;
    #1 chk_now("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sa(1, 1, 1, 0, 0, 0, 1, 0, "t1_s1");
    sa(1, 3, 1, 0, 0, 0, 2, 0, "t1_s2");
    sa(1, 15, 1, 0, 0, 0, 3, 0, "t1_armed");
    sa(0, 0, 1, 0, 1, 0, 3, 0, "t1_open");
    sa(1, 1, 0, 0, 1, 0, 3, 0, "t5_open_sym");
    sa(0, 0, 0, 1, 0, 0, 0, 0, "t5_relock");

    sa(1, 1, 0, 0, 0, 0, 1, 0, "t2_s1");
    sa(1, 3, 0, 0, 0, 0, 2, 0, "t2_s2");
    sa(1, 7, 0, 0, 0, 0, 0, 1, "t2_wrong");
    sa(1, 1, 0, 0, 0, 0, 1, 1, "t2_r1");
    sa(1, 1, 0, 0, 0, 0, 1, 2, "t2_resync");
    sa(1, 3, 1, 0, 0, 0, 2, 2, "t2_s2b");
    sa(1, 15, 1, 0, 0, 0, 3, 2, "t2_armed");
    sa(0, 0, 1, 0, 1, 0, 3, 0, "t2_open");
    sa(0, 0, 0, 1, 0, 0, 0, 0, "t2_relock");

    bad_tries();
    foreach (hs[i]) sa(1, hs[i], 1, 0, 0, 1, 0, 3, "t3_hold");
    sa(0, 0, 0, 0, 0, 0, 0, 0, "t3_expire");

    sa(1, 1, 0, 0, 0, 0, 1, 0, "t4_s1");
    sa(1, 3, 0, 0, 0, 0, 2, 0, "t4_s2");
    sa(1, 15, 0, 0, 0, 0, 3, 0, "t4_armed");
    repeat (15) sa(0, 0, 0, 0, 0, 0, 3, 0, "t4_wait");
    sa(0, 0, 0, 0, 0, 0, 0, 1, "t4_timeout");
    sa(1, 1, 0, 0, 0, 0, 1, 1, "t4b_s1");
    sa(1, 3, 0, 0, 0, 0, 2, 1, "t4b_s2");
    sa(1, 15, 0, 0, 0, 0, 3, 1, "t4b_armed");
    repeat (15) sa(0, 0, 0, 0, 0, 0, 3, 1, "t4b_wait");
    sa(0, 0, 1, 0, 1, 0, 3, 0, "t4b_arm_last");
    sa(0, 0, 0, 1, 0, 0, 0, 0, "t4b_relock");

    bad_tries();
    sa(1, 1, 1, 0, 0, 1, 0, 3, "t5_lk_hold");
    rst_mid("t5_rst_lockout");
    sa(0, 0, 0, 0, 0, 0, 0, 0, "t5_after_lk");
    sa(1, 1, 0, 0, 0, 0, 1, 0, "t5_e1");
    sa(1, 3, 0, 0, 0, 0, 2, 0, "t5_e2");
    rst_mid("t5_rst_entry");
    sa(1, 1, 0, 0, 0, 0, 1, 0, "t5_restart");

    sb(1, 1, 0, 0, 1, 0, "t6_b1");
    sb(1, 1, 0, 0, 2, 0, "t6_b2");
    sb(1, 1, 0, 0, 1, 1, "t6_resync");
    sb(1, 1, 0, 0, 2, 1, "t6_b4");
    sb(1, 0, 0, 0, 3, 1, "t6_b5");
    sb(1, 1, 0, 0, 4, 1, "t6_armed");
    sb(0, 0, 0, 1, 4, 0, "t6_open");
    sb(0, 0, 1, 0, 0, 0, "t6_relock");
    repeat (3) sb(1, 0, 0, 0, 0, 0, "t6_zeros");

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_code_lock.md
Name: seq_code_lock

Overview:
- Parametrised successor to the fixed serial-password and fixed-code unlock machines that gate the main game FSM.
- Accepts a stream of SYM_W-bit symbols, one per sym_vld strobe, and matches them against a CODE_LEN-symbol code parameter.
- A full match must be confirmed with an arm input; the block then holds unlocked until relocked.
- Adds behaviour the fixed machines lack: failed-attempt counting, timed lockout, arm timeout and re-sync on a wrong symbol. Its unlocked output drives the enable/secret inputs of the main FSM.

Parameters:
SYM_W, 4, symbol width in bits
CODE_LEN, 3, number of symbols in the code (>=1)
CODE, 12'hF31, packed code; symbol i = CODE[i*SYM_W +: SYM_W], i=0 entered first (default sequence 1,3,15)
MAX_FAIL, 3, failed attempts that trigger lockout (>=1)
LOCK_CYC, 8, cycles lockout stays asserted (>=1)
ARM_TIMEOUT, 16, maximum cycles spent waiting for arm after a full match (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sym_vld  in  1  sym is valid this cycle
sym  in  SYM_W  entered symbol
arm  in  1  level; confirms a completed code
relock  in  1  level; closes the lock from OPEN
unlocked  out  1  lock open
lockout  out  1  lockout in progress
progress  out  clog2(CODE_LEN+1)  symbols matched so far
fails  out  clog2(MAX_FAIL+1)  failed attempts since last success or lockout

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- rst_n=0 forces, immediately and without a clock: state ENTER, idx=0, timer=0, unlocked=0, lockout=0, progress=0, fails=0. This holds from any state, including mid-lockout.
- All outputs are registered and update on the rising edge that samples the causing input (1-cycle latency).
- Lock states are ENTER, ARMED, OPEN and LOCKOUT.
- ENTER, with sym_vld=1 and sym==CODE[idx]:
  - idx<CODE_LEN-1: idx++.
  - idx==CODE_LEN-1: go to ARMED, idx=0, timer=ARM_TIMEOUT-1.
- ENTER, with sym_vld=1 and a mismatch:
  - idx==0: stay, no fail counted.
  - idx>0: fails++. If fails reaches MAX_FAIL, go to LOCKOUT with timer=LOCK_CYC-1. Otherwise idx = (sym==CODE[0]) ? 1 : 0 (re-sync on the first symbol).
- ENTER, with sym_vld=0: hold.
- ARMED:
  - sym_vld is ignored.
  - arm=1: go to OPEN, fails=0.
  - arm=0 and timer==0: go to ENTER, fails++, with the same lockout check as above.
  - Otherwise timer--.
  - arm=1 in the timeout cycle: arm wins and the block opens.
  - arm already high on entry: OPEN on the next edge.
- OPEN:
  - unlocked=1.
  - sym_vld and arm are ignored.
  - relock=1: go to ENTER, idx=0, unlocked=0 on the next edge.
- LOCKOUT:
  - lockout=1 for exactly LOCK_CYC cycles.
  - sym_vld, arm and relock are ignored.
  - At timer==0: go to ENTER, fails=0.
- relock is ignored outside OPEN.
- progress: idx in ENTER, CODE_LEN in ARMED and OPEN, 0 in LOCKOUT.
- fails saturates at MAX_FAIL and never wraps.
- Timer width is clog2(max(LOCK_CYC,ARM_TIMEOUT)).
- CODE_LEN=1: the first correct symbol goes straight to ARMED.
- Elaboration error if CODE_LEN, MAX_FAIL, LOCK_CYC or ARM_TIMEOUT is less than 1, or if CODE width != SYM_W*CODE_LEN.

Decomposition:
- Package seq_lock_pkg: state enum (ENTER, ARMED, OPEN, LOCKOUT, 2-bit encoding) and a clog2 helper function.
- One natural sub-module, lock_timer: a loadable down-counter with load value, load, en and zero flag. It is shared between the arm timeout and the lockout, since the two are never active together.
- The top level holds the state register, idx, the fails counter and the compare mux.

Test Plan:
1. Reset, arm=1 held, symbols 1,3,15 on consecutive cycles -> progress 1,2,3; unlocked=1 one edge after ARMED is entered; fails=0.
2. Wrong symbol, then re-sync:
   - Symbols 1,3,7 -> fails=1, progress=0.
   - Then 1,1 -> fails=2, progress=1 (re-sync).
   - Then 3,15 with arm=1 -> unlocked=1, fails=0.
3. Lockout:
   - Symbols 1,2 repeated three times -> lockout=1 for exactly 8 cycles.
   - 1,3,15 sent during lockout -> ignored, progress stays 0.
   - On expiry -> lockout=0, fails=0.
4. Arm timeout: 1,3,15 with arm=0 -> ARMED lasts 16 cycles, then ENTER, fails=1, unlocked never 1. Rerun with arm=1 exactly on the 16th cycle -> unlocked=1.
5. Relock and reset:
   - In OPEN, pulse sym_vld with sym=1 -> ignored.
   - relock=1 -> unlocked=0 next edge, progress=0.
   - In separate runs, drop rst_n mid-lockout and mid-code entry -> all outputs 0 immediately, with no clock edge.
6. Serial-password configuration: SYM_W=1, CODE_LEN=4, CODE=4'b1011 (serial 1,1,0,1), arm tied 1.
   - Bits 1,1,1,0,1 -> second-position mismatch at the third bit re-syncs to idx=1, fails=1, then opens.
   - Bits 0,0,0 alone -> fails stays 0.
